// File: rtl/tile_plane_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tile_plane_shifter
// Brief    : Per-plane tile pixel serializer with 3-bit fine scroll window.
// Revision : 1.0  initial release
// ============================================================================
module tile_plane_shifter (
    input  logic        clk_24M,
    input  logic        RES,
    input  logic        PIX_CE,
    input  logic        LOAD,
    input  logic [31:0] ROM_D,
    input  logic [7:0]  COL,
    input  logic        HFLIP,
    input  logic [2:0]  FINE,
    input  logic        BLANK,
    output logic [3:0]  PIX,
    output logic [7:0]  PAL,
    output logic        OPAQUE
);

    localparam int c_DEPTH = 15;
    localparam int c_TILE  = 8;

    logic [11:0] r_win  [0:c_DEPTH-1];
    logic [11:0] w_next [0:c_DEPTH-1];
    logic [3:0]  w_dec  [0:c_TILE-1];
    logic [11:0] w_sel;
    logic [3:0]  r_pix;
    logic [7:0]  r_pal;
    logic        r_opaque;

    // Planar decode: plane p lives in byte p, pixel 0 is the MSB unless flipped.
    always_comb begin
        for (int k = 0; k < c_TILE; k++) begin
            w_dec[k] = 4'h0;
            for (int p = 0; p < 4; p++) begin
                w_dec[k][p] = HFLIP ? ROM_D[8*p + k] : ROM_D[8*p + 7 - k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < c_DEPTH - 1; i++) begin
            w_next[i] = r_win[i+1];
        end
        w_next[c_DEPTH-1] = 12'h000;
        if (LOAD) begin
            for (int k = 0; k < c_TILE; k++) begin
                w_next[7+k] = {w_dec[k], COL};
            end
        end
    end

    assign w_sel = r_win[FINE];

    always_ff @(posedge clk_24M or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_win[i] <= 12'h000;
            end
            r_pix    <= 4'h0;
            r_pal    <= 8'h00;
            r_opaque <= 1'b0;
        end else if (PIX_CE) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_win[i] <= w_next[i];
            end
            r_pix    <= BLANK ? 4'h0 : w_sel[11:8];
            r_pal    <= w_sel[7:0];
            r_opaque <= (w_sel[11:8] != 4'h0) & ~BLANK;
        end
    end

    assign PIX    = r_pix;
    assign PAL    = r_pal;
    assign OPAQUE = r_opaque;

endmodule
`default_nettype wire

// File: tb/tb_tile_plane_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_plane_shifter
// Brief    : Directed self-checking bench for tile_plane_shifter.
// Revision : 1.0  initial release
// ============================================================================
module tb_tile_plane_shifter;

    logic        clk_24M;
    logic        RES;
    logic        PIX_CE;
    logic        LOAD;
    logic [31:0] ROM_D;
    logic [7:0]  COL;
    logic        HFLIP;
    logic [2:0]  FINE;
    logic        BLANK;
    logic [3:0]  PIX;
    logic [7:0]  PAL;
    logic        OPAQUE;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] c_ROM_P = 32'h80402010;
    localparam logic [31:0] c_ROM_A = 32'h000000FF;
    localparam logic [31:0] c_ROM_B = 32'h0000FF00;

    tile_plane_shifter u_dut (
        .clk_24M (clk_24M),
        .RES     (RES),
        .PIX_CE  (PIX_CE),
        .LOAD    (LOAD),
        .ROM_D   (ROM_D),
        .COL     (COL),
        .HFLIP   (HFLIP),
        .FINE    (FINE),
        .BLANK   (BLANK),
        .PIX     (PIX),
        .PAL     (PAL),
        .OPAQUE  (OPAQUE)
    );

    initial begin
        clk_24M = 1'b0;
        forever #5 clk_24M = ~clk_24M;
    end

    // Observed value packed as {PIX, PAL, OPAQUE}.
    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pix=%h pal=%h opq=%b, want pix=%h pal=%h opq=%b",
                     tag, obs[12:9], obs[8:1], obs[0], exp[12:9], exp[8:1], exp[0]);
        end
    endtask

    function automatic logic [12:0] ev(input logic [3:0] p, input logic [7:0] c, input logic o);
        return {p, c, o};
    endfunction

    task automatic step(input logic ld, input logic [31:0] rom, input logic [7:0] col,
                        input logic hf, input logic [2:0] fine, input logic blk);
        PIX_CE = 1'b1;
        LOAD   = ld;
        ROM_D  = rom;
        COL    = col;
        HFLIP  = hf;
        FINE   = fine;
        BLANK  = blk;
        @(posedge clk_24M);
        #1;
        LOAD   = 1'b0;
    endtask

    task automatic flush();
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 8'h00, 1'b0, 3'd0, 1'b0);
    endtask

    logic [3:0] exp_p [0:7];
    logic [3:0] exp_f [0:7];

    initial begin
        RES    = 1'b1;
        PIX_CE = 1'b0;
        LOAD   = 1'b0;
        ROM_D  = 32'h0;
        COL    = 8'h00;
        HFLIP  = 1'b0;
        FINE   = 3'd0;
        BLANK  = 1'b0;
        exp_p  = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_f  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
        repeat (2) @(posedge clk_24M);
        #1;
        chk("reset_state", {PIX, PAL, OPAQUE}, ev(4'h0, 8'h00, 1'b0));
        RES = 1'b0;

        // Planar decode, no flip.
        for (int e = 0; e < 16; e++) begin
            step(e == 0, c_ROM_P, 8'h5A, 1'b0, 3'd0, 1'b0);
            if (e >= 8)
                chk($sformatf("planar_e%0d", e), {PIX, PAL, OPAQUE},
                    ev(exp_p[e-8], 8'h5A, exp_p[e-8] != 4'h0));
        end
        flush();

        // Horizontal flip.
        for (int e = 0; e < 16; e++) begin
            step(e == 0, c_ROM_P, 8'h5A, 1'b1, 3'd0, 1'b0);
            if (e >= 8)
                chk($sformatf("hflip_e%0d", e), {PIX, PAL, OPAQUE},
                    ev(exp_f[e-8], 8'h5A, exp_f[e-8] != 4'h0));
        end
        flush();

        // Fine scroll 3 across tile seam A -> B -> C(empty).
        for (int e = 0; e < 22; e++) begin
            if (e == 0)       step(1'b1, c_ROM_A, 8'h11, 1'b0, 3'd3, 1'b0);
            else if (e == 8)  step(1'b1, c_ROM_B, 8'h22, 1'b0, 3'd3, 1'b0);
            else if (e == 16) step(1'b1, 32'h0,   8'h33, 1'b0, 3'd3, 1'b0);
            else              step(1'b0, 32'h0,   8'h00, 1'b0, 3'd3, 1'b0);
            if (e >= 5 && e <= 12)
                chk($sformatf("fine3_A_e%0d", e), {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
            else if (e >= 13 && e <= 20)
                chk($sformatf("fine3_B_e%0d", e), {PIX, PAL, OPAQUE}, ev(4'h2, 8'h22, 1'b1));
            else if (e == 21)
                chk("fine3_C_e21", {PIX, PAL, OPAQUE}, ev(4'h0, 8'h33, 1'b0));
        end
        flush();

        // Single blanked pixel mid-tile.
        for (int e = 0; e < 12; e++) begin
            step(e == 0 || e == 8, c_ROM_A, 8'h11, 1'b0, 3'd0, e == 10);
            if (e == 9)  chk("blank_pre",  {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
            if (e == 10) chk("blank_on",   {PIX, PAL, OPAQUE}, ev(4'h0, 8'h11, 1'b0));
            if (e == 11) chk("blank_post", {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
        end
        flush();

        // Missing load at e8: zeros fill e16..e23, tile B resumes at e24.
        for (int e = 0; e < 25; e++) begin
            step(e == 0 || e == 16, (e == 0) ? c_ROM_A : c_ROM_B,
                 (e == 0) ? 8'h11 : 8'h22, 1'b0, 3'd0, 1'b0);
            if (e == 15)
                chk("gap_lastA", {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
            else if (e >= 16 && e <= 23)
                chk($sformatf("gap_zero_e%0d", e), {PIX, PAL, OPAQUE}, ev(4'h0, 8'h00, 1'b0));
            else if (e == 24)
                chk("gap_B", {PIX, PAL, OPAQUE}, ev(4'h2, 8'h22, 1'b1));
        end
        flush();

        // PIX_CE gating: 20 idle clocks with garbage inputs after e9.
        for (int e = 0; e < 10; e++) step(e == 0, c_ROM_A, 8'h11, 1'b0, 3'd0, 1'b0);
        chk("gate_before", {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
        for (int c = 0; c < 20; c++) begin
            PIX_CE = 1'b0;
            LOAD   = c[0];
            ROM_D  = $urandom | 32'hF0F0F0F0;
            COL    = 8'hEE;
            HFLIP  = c[1];
            FINE   = 3'(c);
            BLANK  = c[2];
            @(posedge clk_24M);
            #1;
            chk($sformatf("gate_hold_c%0d", c), {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
        end
        for (int e = 10; e < 18; e++) begin
            step(1'b0, 32'h0, 8'h00, 1'b0, 3'd0, 1'b0);
            if (e <= 15)
                chk($sformatf("gate_resume_e%0d", e), {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
            else
                chk($sformatf("gate_tail_e%0d", e), {PIX, PAL, OPAQUE}, ev(4'h0, 8'h00, 1'b0));
        end
        flush();

        // Asynchronous reset mid-stream with the window full.
        for (int e = 0; e < 10; e++) step(e == 0 || e == 8, c_ROM_A, 8'h11, 1'b0, 3'd0, 1'b0);
        chk("rst_pre", {PIX, PAL, OPAQUE}, ev(4'h1, 8'h11, 1'b1));
        #2;
        RES = 1'b1;
        #1;
        chk("rst_async", {PIX, PAL, OPAQUE}, ev(4'h0, 8'h00, 1'b0));
        @(posedge clk_24M);
        #1;
        RES = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 32'h0, 8'h00, 1'b0, 3'd0, 1'b0);
            chk($sformatf("rst_after_e%0d", e), {PIX, PAL, OPAQUE}, ev(4'h0, 8'h00, 1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
